bottle_fill_ctrl: RTL and testbench
===================================

# bottle_fill_ctrl

Sequencing controller for the bottle-filling datapath. Takes the per-bottle pill limit (two BCD digits, maxH:maxL), opens the fill valve when an empty bottle is in position, and counts pill-sensor pulses up to the limit. On reaching the limit it closes the valve and hands the bottle to the conveyor. It also keeps a running BCD count of completed bottles. It sits between the limit-setting logic, the pill sensor, the valve driver and the conveyor.

## Interface
Parameters: none.
- CLK  in  1  system clock, rising edge
- RST_n  in  1  reset; asynchronous, active-low
- EN_work  in  1  work mode; filling allowed only while high
- EN_set  in  1  set mode; high forces abort/idle
- start  in  1  single-cycle request to begin a run
- pill  in  1  single-cycle pulse per pill detected (already synchronized)
- maxL, maxH  in  4 each  per-bottle limit, BCD units/tens
- bottle_ready  in  1  conveyor: empty bottle in position (level)
- valve_open  out  1  fill valve gate
- advance  out  1  conveyor move request (level, handshake)
- full  out  1  single-cycle pulse: bottle completed
- busy  out  1  state ≠ IDLE
- err  out  1  sticky: pill seen while valve closed
- numL, numH  out  4 each  pills in current bottle, BCD
- totL, totH  out  4 each  completed bottles, BCD, wraps 99→00

## Operation
- Reset: state IDLE. All outputs and the latched target go to 0.
- Target latch: on an accepted start, tgtH:tgtL ← maxH:maxL. Each digit above 9 is clamped to 9. Limit changes during a run have no effect.
- IDLE: valve_open=0, advance=0.
  - start && EN_work && !EN_set with latched target ≠ 00 → WAIT_BOTTLE. This also clears err and num.
  - A start with target 00 is ignored.
- WAIT_BOTTLE: on bottle_ready=1 → FILL, and num cleared to 00.
- FILL: valve_open=1. Each pill increments num (BCD; units 9→0 carries into tens).
  - When the incremented value equals the target: num takes the target value, full pulses, tot increments, and the state goes to ADVANCE.
- ADVANCE: valve_open=0, advance=1. Hold until bottle_ready=0, then → WAIT_BOTTLE. advance drops on that same transition.
- Abort: in any non-IDLE state, EN_work=0 or EN_set=1 → IDLE next cycle. The valve closes; num and tot are retained.
- Abort priority: abort beats a same-cycle pill (pill not counted, err not set) and beats completion (no full pulse).
- err: set by a pill in any state other than FILL, or by a pill in the cycle FILL is left. Cleared only by an accepted start or by reset.
- start while busy: ignored.
- tot wraps 99→00 silently.

## Timing
- All outputs are registered.
- Count latency: num changes the cycle after the pill pulse.
- The full pulse is coincident with num reaching the target and with the first ADVANCE cycle.
- valve_open rises 1 cycle after bottle_ready is sampled high in WAIT_BOTTLE. It falls in the same cycle that full is asserted.
- Back-to-back pills (every cycle) are all counted. The pill that completes the bottle is the last one counted; a pill in the next cycle sets err.
- Minimum bottle cycle: 1 (WAIT) + N pills + 1 (ADVANCE) + conveyor latency.
- Reset is asynchronous: mid-run assertion closes the valve immediately, with no full pulse.

## Structure
- Shared package bottle_pkg holds:
  - state enum {IDLE, WAIT_BOTTLE, FILL, ADVANCE}
  - BCD digit type (4-bit)
  - constant BCD_MAX=4'd9
  - digit clamp function
- Sub-module bcd2_counter: two-digit BCD counter with synchronous clear, inc, wrap and carry-out. It is instantiated twice, once for num and once for tot.
- The FSM and target latch live in bottle_fill_ctrl.

## Test plan
- Limit 0:3, start, bottle_ready=1, 3 pills spaced 2 cycles → num 01,02,03; full pulses once; tot=01; advance=1 until bottle_ready drops.
- Limit H=1 L=0xC (clamped to 19): 19 pills every cycle → num 09→10 carry correct; full on the 19th pill; a 20th pill in the next cycle sets err, and num stays 19.
- Mid-fill at num=05: EN_set=1 together with a pill → IDLE next cycle; valve_open=0; num stays 05; no full; err=0.
- tot preset to 99 via 99 bottles at limit 01 → 100th completion gives tot=00.
- Pill while in IDLE → err=1. A later valid start clears err; a start with limit 00 is ignored (busy stays 0).
- RST_n low during FILL → valve_open, busy, num, tot, err all 0 asynchronously; state IDLE after release.

Source files
------------

// File: rtl/bottle_pkg.sv
// Shared types and helpers for the bottle-filling controller.
//   state_e   : controller states
//   bcd_t     : one BCD digit
//   BCD_MAX   : largest legal BCD digit
//   bcd_clamp : limits a digit to 0..9
package bottle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BOTTLE,
    FILL,
    ADVANCE
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bottle_fill_ctrl_if.sv
// Signal bundle between the controller and its surroundings (limit logic,
// pill sensor, valve driver, conveyor).
//   master : drives EN_work, EN_set, start, pill, maxL/maxH, bottle_ready
//   slave  : the controller; drives valve_open, advance, full, busy, err,
//            numL/numH (pills in bottle), totL/totH (bottles done)
interface bottle_fill_ctrl_if;
  import bottle_pkg::*;

  logic EN_work;
  logic EN_set;
  logic start;
  logic pill;
  bcd_t maxL;
  bcd_t maxH;
  logic bottle_ready;

  logic valve_open;
  logic advance;
  logic full;
  logic busy;
  logic err;
  bcd_t numL;
  bcd_t numH;
  bcd_t totL;
  bcd_t totH;

  modport master (
    output EN_work, EN_set, start, pill, maxL, maxH, bottle_ready,
    input  valve_open, advance, full, busy, err, numL, numH, totL, totH
  );

  modport slave (
    input  EN_work, EN_set, start, pill, maxL, maxH, bottle_ready,
    output valve_open, advance, full, busy, err, numL, numH, totL, totH
  );

endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter, 00..99, wrapping to 00.
//   clk, rst_n         : clock, async active-low reset
//   i_clr              : synchronous clear (wins over i_inc)
//   i_inc              : count up by one
//   o_lo, o_hi         : current value
//   o_nxt_lo, o_nxt_hi : value after one increment (for look-ahead compare)
//   o_carry            : high when i_inc wraps 99 -> 00
module bcd2_counter
  import bottle_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output bcd_t o_lo,
  output bcd_t o_hi,
  output bcd_t o_nxt_lo,
  output bcd_t o_nxt_hi,
  output logic o_carry
);

  bcd_t r_lo;
  bcd_t r_hi;
  bcd_t w_nxt_lo;
  bcd_t w_nxt_hi;
  logic w_wrap;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_nxt_lo = r_lo + 4'd1;
    w_nxt_hi = r_hi;
    w_wrap   = 1'b0;
    if (r_lo == BCD_MAX) begin
      w_nxt_lo = 4'd0;
      if (r_hi == BCD_MAX) begin
        w_nxt_hi = 4'd0;
        w_wrap   = 1'b1;
      end else begin
        w_nxt_hi = r_hi + 4'd1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo <= 4'd0;
      r_hi <= 4'd0;
    end else if (i_clr) begin
      r_lo <= 4'd0;
      r_hi <= 4'd0;
    end else if (i_inc) begin
      r_lo <= w_nxt_lo;
      r_hi <= w_nxt_hi;
    end
  end

  assign o_lo     = r_lo;
  assign o_hi     = r_hi;
  assign o_nxt_lo = w_nxt_lo;
  assign o_nxt_hi = w_nxt_hi;
  assign o_carry  = i_inc && !i_clr && w_wrap;

endmodule

// File: rtl/bottle_fill_ctrl.sv
// Bottle-filling sequencer: latches the per-bottle pill limit on start, opens
// the valve on an empty bottle, counts pills to the limit, then asks the
// conveyor to advance. Keeps a running BCD count of completed bottles.
//   CLK, RST_n : clock, async active-low reset
//   bus        : controller side of bottle_fill_ctrl_if (all outputs registered)
module bottle_fill_ctrl
  import bottle_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_n,
  bottle_fill_ctrl_if.slave  bus
);

  state_e r_state;
  state_e w_next;
  bcd_t   r_tgt_h;
  bcd_t   r_tgt_l;
  logic   r_valve;
  logic   r_adv;
  logic   r_full;
  logic   r_busy;
  logic   r_err;

  bcd_t   w_lim_h;
  bcd_t   w_lim_l;
  logic   w_abort;
  logic   w_accept;
  logic   w_num_clr;
  logic   w_num_inc;
  logic   w_done;
  logic   w_err_set;

  bcd_t   w_num_l;
  bcd_t   w_num_h;
  bcd_t   w_num_nxt_l;
  bcd_t   w_num_nxt_h;
  bcd_t   w_tot_l;
  bcd_t   w_tot_h;
  logic   w_num_carry_unused;
  logic   w_tot_carry_unused;
  logic [7:0] w_tot_nxt_unused;

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_num_clr = 1'b0;
    w_num_inc = 1'b0;
    w_done    = 1'b0;
    w_lim_h   = bcd_clamp(bus.maxH);
    w_lim_l   = bcd_clamp(bus.maxL);
    // Abort outranks everything in a running state, including a pill or a
    // completing pill in the same cycle.
    w_abort   = (r_state != IDLE) && (!bus.EN_work || bus.EN_set);
    w_err_set = bus.pill && !w_abort && (r_state != FILL);

    if (w_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && bus.EN_work && !bus.EN_set &&
              ({w_lim_h, w_lim_l} != 8'h00)) begin
            w_accept  = 1'b1;
            w_num_clr = 1'b1;
            w_next    = WAIT_BOTTLE;
          end
        end
        WAIT_BOTTLE: begin
          if (bus.bottle_ready) begin
            w_num_clr = 1'b1;
            w_next    = FILL;
          end
        end
        FILL: begin
          if (bus.pill) begin
            w_num_inc = 1'b1;
            // num never exceeds the target, so look-ahead equality suffices.
            if ({w_num_nxt_h, w_num_nxt_l} == {r_tgt_h, r_tgt_l}) begin
              w_done = 1'b1;
              w_next = ADVANCE;
            end
          end
        end
        ADVANCE: begin
          if (!bus.bottle_ready) w_next = WAIT_BOTTLE;
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // NOTE: only the control flops and target need reset here; the design holds
  // no memory arrays, so every storage element is cleared asynchronously.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state <= IDLE;
      r_tgt_h <= 4'd0;
      r_tgt_l <= 4'd0;
      r_valve <= 1'b0;
      r_adv   <= 1'b0;
      r_full  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_tgt_h <= w_lim_h;
        r_tgt_l <= w_lim_l;
      end
      // Outputs decode the next state so they line up with the state itself.
      r_valve <= (w_next == FILL);
      r_adv   <= (w_next == ADVANCE);
      r_busy  <= (w_next != IDLE);
      r_full  <= w_done;
      r_err   <= (r_err && !w_accept) || w_err_set;
    end
  end

  bcd2_counter u_num (
    .clk      (CLK),
    .rst_n    (RST_n),
    .i_clr    (w_num_clr),
    .i_inc    (w_num_inc),
    .o_lo     (w_num_l),
    .o_hi     (w_num_h),
    .o_nxt_lo (w_num_nxt_l),
    .o_nxt_hi (w_num_nxt_h),
    .o_carry  (w_num_carry_unused)
  );

  bcd2_counter u_tot (
    .clk      (CLK),
    .rst_n    (RST_n),
    .i_clr    (1'b0),
    .i_inc    (w_done),
    .o_lo     (w_tot_l),
    .o_hi     (w_tot_h),
    .o_nxt_lo (w_tot_nxt_unused[3:0]),
    .o_nxt_hi (w_tot_nxt_unused[7:4]),
    .o_carry  (w_tot_carry_unused)
  );

  assign bus.valve_open = r_valve;
  assign bus.advance    = r_adv;
  assign bus.full       = r_full;
  assign bus.busy       = r_busy;
  assign bus.err        = r_err;
  assign bus.numL       = w_num_l;
  assign bus.numH       = w_num_h;
  assign bus.totL       = w_tot_l;
  assign bus.totH       = w_tot_h;

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Self-checking bench for bottle_fill_ctrl: an integer-level model of the
// fill sequence is compared against the DUT every cycle, and directed
// scenarios add hand-computed expectations.
module tb_bottle_fill_ctrl;

  logic CLK;
  logic RST_n;
  int   n_total;
  int   n_bad;

  bottle_fill_ctrl_if bus ();

  bottle_fill_ctrl dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [20:0] dut_outs();
    return {bus.valve_open, bus.advance, bus.full, bus.busy, bus.err,
            bus.numH, bus.numL, bus.totH, bus.totL};
  endfunction

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_WAIT = 1, PH_FILL = 2, PH_ADV = 3;
  int m_ph, m_num, m_tot, m_tgt;
  bit m_err, m_full;

  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      m_ph = PH_IDLE; m_num = 0; m_tot = 0; m_tgt = 0; m_err = 0; m_full = 0;
    end else begin
      int lim;
      bit abrt, set_err, clr_err;
      lim     = ((bus.maxH > 9) ? 9 : int'(bus.maxH)) * 10 +
                ((bus.maxL > 9) ? 9 : int'(bus.maxL));
      abrt    = (m_ph != PH_IDLE) && (!bus.EN_work || bus.EN_set);
      set_err = bus.pill && !abrt && (m_ph != PH_FILL);
      clr_err = 0;
      m_full  = 0;
      if (abrt) m_ph = PH_IDLE;
      else if (m_ph == PH_IDLE) begin
        if (bus.start && bus.EN_work && !bus.EN_set && lim != 0) begin
          m_tgt = lim; m_num = 0; clr_err = 1; m_ph = PH_WAIT;
        end
      end else if (m_ph == PH_WAIT) begin
        if (bus.bottle_ready) begin m_num = 0; m_ph = PH_FILL; end
      end else if (m_ph == PH_FILL) begin
        if (bus.pill) begin
          m_num++;
          if (m_num == m_tgt) begin
            m_full = 1; m_tot = (m_tot + 1) % 100; m_ph = PH_ADV;
          end
        end
      end else begin
        if (!bus.bottle_ready) m_ph = PH_WAIT;
      end
      m_err = (clr_err ? 1'b0 : m_err) | set_err;
    end
  end

  function automatic logic [20:0] model_outs();
    return {m_ph == PH_FILL, m_ph == PH_ADV, m_full, m_ph != PH_IDLE, m_err,
            4'(m_num / 10), 4'(m_num % 10), 4'(m_tot / 10), 4'(m_tot % 10)};
  endfunction

  always @(negedge CLK) check("model_vs_dut", 32'(dut_outs()), 32'(model_outs()));

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_start();
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
  endtask

  task automatic do_pill();
    bus.pill = 1'b1; tick(1); bus.pill = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_bad = 0;
    RST_n = 1'b0;
    bus.EN_work = 0; bus.EN_set = 0; bus.start = 0; bus.pill = 0;
    bus.maxL = 0; bus.maxH = 0; bus.bottle_ready = 0;
    tick(2);
    RST_n = 1'b1;
    tick(1);
    check("reset_outs", 32'(dut_outs()), 32'd0);

    // Limit 03, pills spaced two cycles apart.
    bus.EN_work = 1; bus.maxH = 4'd0; bus.maxL = 4'd3;
    do_start();
    check("t1_busy", 32'(bus.busy), 32'd1);
    bus.bottle_ready = 1;
    tick(1);
    check("t1_valve", 32'(bus.valve_open), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      do_pill();
      check("t1_num", 32'({bus.numH, bus.numL}), 32'(i));
      if (i == 3) check("t1_full_adv_valve", 32'({bus.full, bus.advance, bus.valve_open}), 32'b110);
      else tick(1);
    end
    tick(2);
    check("t1_adv_hold", 32'({bus.advance, bus.full}), 32'b10);
    bus.bottle_ready = 0;
    tick(1);
    check("t1_adv_drop", 32'(bus.advance), 32'd0);
    check("t1_tot", 32'({bus.totH, bus.totL}), 32'h01);

    // Limit 1:C clamps to 19; back-to-back pills, extra pill sets err.
    bus.EN_work = 0; tick(1); bus.EN_work = 1;
    bus.maxH = 4'd1; bus.maxL = 4'hC;
    do_start();
    bus.bottle_ready = 1; tick(1);
    bus.pill = 1;
    for (int i = 1; i <= 19; i++) begin
      tick(1);
      check("t2_num", 32'({bus.numH, bus.numL}), 32'({4'(i / 10), 4'(i % 10)}));
      if (i == 10) check("t2_carry", 32'({bus.numH, bus.numL}), 32'h10);
      if (i == 18) check("t2_no_full", 32'(bus.full), 32'd0);
    end
    check("t2_full19", 32'(bus.full), 32'd1);
    tick(1);
    bus.pill = 0;
    check("t2_err_num", 32'({bus.err, bus.numH, bus.numL}), 32'h119);
    check("t2_tot", 32'({bus.totH, bus.totL}), 32'h02);
    bus.bottle_ready = 0; tick(1);

    // Abort with EN_set coincident with a pill at num=05.
    bus.EN_work = 0; tick(1); bus.EN_work = 1;
    bus.maxH = 4'd0; bus.maxL = 4'd9;
    do_start();
    check("t3_err_cleared", 32'(bus.err), 32'd0);
    bus.bottle_ready = 1; tick(1);
    bus.pill = 1; tick(5);
    check("t3_num5", 32'({bus.numH, bus.numL}), 32'h05);
    bus.EN_set = 1; tick(1);
    bus.pill = 0; bus.EN_set = 0;
    check("t3_abort", 32'({bus.busy, bus.valve_open, bus.full, bus.err, bus.numH, bus.numL}), 32'h005);
    bus.bottle_ready = 0;

    // tot wraps 99 -> 00 with limit 01.
    bus.maxL = 4'd1;
    do_start();
    for (int b = 0; b < 97; b++) begin
      bus.bottle_ready = 1; tick(1);
      bus.pill = 1; tick(1);
      bus.pill = 0; bus.bottle_ready = 0; tick(1);
    end
    check("t4_tot99", 32'({bus.totH, bus.totL}), 32'h99);
    bus.bottle_ready = 1; tick(1);
    bus.pill = 1; tick(1);
    check("t4_tot00", 32'({bus.full, bus.totH, bus.totL}), 32'h100);
    bus.pill = 0; bus.bottle_ready = 0; tick(1);

    // Pill in IDLE sets err; zero limit ignored; valid start clears err.
    bus.EN_work = 0; tick(1); bus.EN_work = 1;
    do_pill();
    check("t5_err_idle", 32'({bus.busy, bus.err}), 32'b01);
    bus.maxL = 4'd0;
    do_start();
    check("t5_zero_limit", 32'({bus.busy, bus.err}), 32'b01);
    bus.maxL = 4'd2;
    do_start();
    check("t5_start_clears", 32'({bus.busy, bus.err}), 32'b10);

    // Asynchronous reset in the middle of a fill.
    bus.bottle_ready = 1; tick(1);
    do_pill();
    check("t6_filling", 32'({bus.valve_open, bus.numH, bus.numL}), 32'h101);
    #2 RST_n = 1'b0;
    #1 check("t6_async_rst", 32'(dut_outs()), 32'd0);
    tick(1);
    RST_n = 1'b1;
    tick(2);
    check("t6_idle_after", 32'({bus.busy, bus.valve_open, bus.full}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
